// File: rtl/csel_adder_pipe_pkg.sv
// Shared widths for the carry-select adder pipeline.
package csel_adder_pipe_pkg;
    localparam int ADD_WIDTH    = 16;
    localparam int ADD_SPLIT    = 8;
    localparam int ADD_HI_WIDTH = ADD_WIDTH - ADD_SPLIT;
endpackage

// File: rtl/mux2.sv
// Single-bit 2:1 mux cell: y = sel ? d1 : d0.
// Purely combinational; no handshake.
module mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);
    assign y = sel ? d1 : d0;
endmodule

// File: rtl/rca_n.sv
// Parameterized ripple-carry adder: N-bit sum plus carry-out.
// Purely combinational; no handshake.
module rca_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);
    logic [N:0] c;

    always_comb begin
        s    = '0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        co = c[N];
    end
endmodule

// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready on both sides.
// Latency: transfer at edge N is presented on out_valid right after edge N+1.
// Backpressure: combinational ready chain, one beat per stage, outputs hold while stalled.
module csel_adder_pipe
    import csel_adder_pipe_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int SPLIT = ADD_SPLIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int HI_W = WIDTH - SPLIT;

    logic             s1_valid;
    logic [SPLIT-1:0] s1_lo_sum;
    logic             s1_lo_c;
    logic [HI_W:0]    s1_hi0;
    logic [HI_W:0]    s1_hi1;
    logic             s2_valid;
    logic             s2_ready;

    logic             in_xfer;
    logic             s1_adv;
    logic             out_xfer;

    logic [SPLIT-1:0] lo_sum_d;
    logic             lo_c_d;
    logic [HI_W-1:0]  hi0_s;
    logic [HI_W-1:0]  hi1_s;
    logic             hi0_c;
    logic             hi1_c;
    logic [HI_W:0]    sel;

    assign s2_ready  = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_ready;
    assign in_xfer   = in_valid && in_ready;
    assign s1_adv    = s1_valid && s2_ready;
    assign out_xfer  = s2_valid && out_ready;
    assign out_valid = s2_valid;

    rca_n #(.N(SPLIT)) u_rca_lo (
        .a  (a[SPLIT-1:0]),
        .b  (b[SPLIT-1:0]),
        .ci (cin),
        .s  (lo_sum_d),
        .co (lo_c_d)
    );

    // Both upper candidates are computed speculatively; stage 2 picks one.
    rca_n #(.N(HI_W)) u_rca_hi0 (
        .a  (a[WIDTH-1:SPLIT]),
        .b  (b[WIDTH-1:SPLIT]),
        .ci (1'b0),
        .s  (hi0_s),
        .co (hi0_c)
    );

    rca_n #(.N(HI_W)) u_rca_hi1 (
        .a  (a[WIDTH-1:SPLIT]),
        .b  (b[WIDTH-1:SPLIT]),
        .ci (1'b1),
        .s  (hi1_s),
        .co (hi1_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_lo_sum <= '0;
            s1_lo_c   <= 1'b0;
            s1_hi0    <= '0;
            s1_hi1    <= '0;
        end else if (in_xfer) begin
            s1_valid  <= 1'b1;
            s1_lo_sum <= lo_sum_d;
            s1_lo_c   <= lo_c_d;
            s1_hi0    <= {hi0_c, hi0_s};
            s1_hi1    <= {hi1_c, hi1_s};
        end else if (s1_adv) begin
            s1_valid  <= 1'b0;
        end
    end

    for (genvar i = 0; i < HI_W + 1; i++) begin : g_sel
        mux2 u_mux (
            .d0  (s1_hi0[i]),
            .d1  (s1_hi1[i]),
            .sel (s1_lo_c),
            .y   (sel[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            sum      <= {sel[HI_W-1:0], s1_lo_sum};
            cout     <= sel[HI_W];
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end
endmodule
